// File: rtl/fpnew_pkg.sv
// Shared helpers for the FPNew issue scheduler slice.
//   idx_width(n) : bits needed to index n requesters, never less than 1.
package fpnew_pkg;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpnew_rr_pick.sv
// Combinational wrap-around priority picker.
//   req_i   : request vector
//   ptr_i   : search start index
//   idx_o   : first set request at or above ptr_i, wrapping to 0
//   found_o : at least one request is set
module fpnew_rr_pick
  import fpnew_pkg::*;
#(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned IdxWidth = idx_width(NumReq)
) (
  input  logic [NumReq-1:0]   req_i,
  input  logic [IdxWidth-1:0] ptr_i,
  output logic [IdxWidth-1:0] idx_o,
  output logic                found_o
);

  logic [IdxWidth-1:0] lo_idx;
  logic [IdxWidth-1:0] hi_idx;
  logic                lo_found;
  logic                hi_found;

  // Descending scan: the last hit written is the lowest index. The "hi"
  // search only sees requests at or above the pointer; the "lo" search is
  // the wrap-around fallback over the whole vector.
  always_comb begin
    lo_idx   = '0;
    hi_idx   = '0;
    lo_found = 1'b0;
    hi_found = 1'b0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_idx   = IdxWidth'(i);
        lo_found = 1'b1;
        if (IdxWidth'(i) >= ptr_i) begin
          hi_idx   = IdxWidth'(i);
          hi_found = 1'b1;
        end
      end
    end
  end

  assign idx_o   = hi_found ? hi_idx : lo_idx;
  assign found_o = lo_found;

endmodule

// File: rtl/fpnew_rr_scheduler.sv
// Round-robin issue scheduler in front of one shared pipelined FPNew unit.
// Requests are arbitrated round-robin, stamped with the requester index on
// the unit aux channel, and the number in flight is bounded by a credit
// counter. Results are routed back by the index returned on the aux output.
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high. Once valid is raised it (and its payload) holds until the transfer;
// ready may depend combinationally on valid.
//
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   flush_i               synchronous flush (drops credits and grant lock)
//   req_valid_i/ready_o   per-requester issue handshake, req_tag_i payload
//   unit_valid_o/ready_i  issue to unit, unit_tag_o/unit_idx_o payload
//   unit_flush_o          flush forwarded to the unit
//   unit_valid_i/ready_o  result from unit, unit_tag_i/unit_idx_i payload
//   rsp_valid_o/ready_i   per-requester result handshake, rsp_tag_o shared
//   busy_o                work in flight or an issue pending
module fpnew_rr_scheduler
  import fpnew_pkg::*;
#(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned MaxInflight = 4,
  parameter type         TagType     = logic,
  localparam int unsigned IdxWidth   = idx_width(NumReq)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [NumReq-1:0]     req_valid_i,
  output logic [NumReq-1:0]     req_ready_o,
  input  TagType [NumReq-1:0]   req_tag_i,
  output logic                  unit_valid_o,
  input  logic                  unit_ready_i,
  output TagType                unit_tag_o,
  output logic [IdxWidth-1:0]   unit_idx_o,
  output logic                  unit_flush_o,
  input  logic                  unit_valid_i,
  output logic                  unit_ready_o,
  input  TagType                unit_tag_i,
  input  logic [IdxWidth-1:0]   unit_idx_i,
  output logic [NumReq-1:0]     rsp_valid_o,
  input  logic [NumReq-1:0]     rsp_ready_i,
  output TagType                rsp_tag_o,
  output logic                  busy_o
);

  localparam int unsigned CntWidth = $clog2(MaxInflight + 1);

  logic [IdxWidth-1:0] ptr;
  logic                lock;
  logic [IdxWidth-1:0] locked_idx;
  logic [CntWidth-1:0] cnt;

  logic [IdxWidth-1:0] pick_idx;
  logic                pick_found;
  logic [IdxWidth-1:0] cand_idx;
  logic                cand_valid;
  logic [IdxWidth-1:0] next_ptr;
  logic                issue_en;
  logic                issue_fire;
  logic                retire_fire;
  logic                idx_ok;

  fpnew_rr_pick #(
    .NumReq   (NumReq),
    .IdxWidth (IdxWidth)
  ) u_pick (
    .req_i   (req_valid_i),
    .ptr_i   (ptr),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // A stalled grant is pinned so valid/tag cannot move under the unit.
  assign cand_idx   = lock ? locked_idx : pick_idx;
  assign cand_valid = lock ? req_valid_i[locked_idx] : pick_found;
  assign issue_en   = (cnt < CntWidth'(MaxInflight));

  assign unit_valid_o = cand_valid & issue_en;
  assign unit_tag_o   = req_tag_i[cand_idx];
  assign unit_idx_o   = cand_idx;
  assign unit_flush_o = flush_i;
  assign issue_fire   = unit_valid_o & unit_ready_i;

  assign next_ptr = (cand_idx == IdxWidth'(NumReq - 1)) ? '0
                                                       : cand_idx + IdxWidth'(1);

  always_comb begin
    req_ready_o = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      req_ready_o[i] = issue_fire & (cand_idx == IdxWidth'(i));
    end
  end

  // Out-of-range indices only exist for non-power-of-2 NumReq; they are
  // never routed and never acknowledged.
  assign idx_ok = (32'(unit_idx_i) < NumReq);

  always_comb begin
    rsp_valid_o = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      rsp_valid_o[i] = unit_valid_i & idx_ok & (unit_idx_i == IdxWidth'(i));
    end
  end

  assign unit_ready_o = idx_ok & rsp_ready_i[unit_idx_i];
  assign rsp_tag_o    = unit_tag_i;
  assign retire_fire  = unit_valid_i & unit_ready_o;

  assign busy_o = (cnt != '0) | unit_valid_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr        <= '0;
      lock       <= 1'b0;
      locked_idx <= '0;
      cnt        <= '0;
    end else if (flush_i) begin
      cnt  <= '0;
      lock <= 1'b0;
    end else begin
      if (issue_fire) begin
        ptr  <= next_ptr;
        lock <= 1'b0;
      end else if (unit_valid_o) begin
        lock       <= 1'b1;
        locked_idx <= cand_idx;
      end
      // issue_en already keeps an issue from pushing cnt past MaxInflight;
      // a retire at zero is a protocol error and is held at zero.
      case ({issue_fire, retire_fire})
        2'b10:   cnt <= cnt + CntWidth'(1);
        2'b01:   if (cnt != '0) cnt <= cnt - CntWidth'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  a_retire_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (retire_fire && !flush_i) |-> (cnt != '0));

  a_rsp_idx_range: assert property (@(posedge clk_i) disable iff (rst_i)
    unit_valid_i |-> idx_ok);

  a_locked_req_held: assert property (@(posedge clk_i) disable iff (rst_i)
    (lock && !flush_i) |-> req_valid_i[locked_idx]);

endmodule

// File: tb/tb_fpnew_rr_scheduler.sv
module tb_fpnew_rr_scheduler;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [3:0][7:0]  req_tag;
  logic             unit_valid_o;
  logic             unit_ready_i;
  logic [7:0]       unit_tag_o;
  logic [1:0]       unit_idx_o;
  logic             unit_flush;
  logic             unit_valid_i;
  logic             unit_ready_o;
  logic [7:0]       unit_tag_i;
  logic [1:0]       unit_idx_i;
  logic [3:0]       rsp_valid;
  logic [3:0]       rsp_ready;
  logic [7:0]       rsp_tag;
  logic             busy;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  fpnew_rr_scheduler #(
    .NumReq      (4),
    .MaxInflight (4),
    .TagType     (logic [7:0])
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_tag_i    (req_tag),
    .unit_valid_o (unit_valid_o),
    .unit_ready_i (unit_ready_i),
    .unit_tag_o   (unit_tag_o),
    .unit_idx_o   (unit_idx_o),
    .unit_flush_o (unit_flush),
    .unit_valid_i (unit_valid_i),
    .unit_ready_o (unit_ready_o),
    .unit_tag_i   (unit_tag_i),
    .unit_idx_i   (unit_idx_i),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_tag_o    (rsp_tag),
    .busy_o       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge, where inputs are driven
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    flush        = 1'b0;
    req_valid    = '0;
    unit_ready_i = 1'b0;
    unit_valid_i = 1'b0;
    unit_tag_i   = '0;
    unit_idx_i   = '0;
    rsp_ready    = '0;
    for (int i = 0; i < 4; i++) req_tag[i] = 8'(8'h10 + i);

    // reset state
    #12;
    chk("rst_unit_valid", 32'(unit_valid_o), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_unit_flush", 32'(unit_flush), 32'd0);
    step();
    rst = 1'b0;

    // fairness: all valid, unit ready -> grants 0,1,2,3 then credits run out
    req_valid = 4'hF; unit_ready_i = 1'b1; #1;
    chk("rr0_idx", 32'(unit_idx_o), 32'd0);
    chk("rr0_tag", 32'(unit_tag_o), 32'h10);
    chk("rr0_ready", 32'(req_ready), 32'b0001);
    chk("rr0_valid", 32'(unit_valid_o), 32'd1);
    chk("rr0_busy", 32'(busy), 32'd1);
    step(); #1;
    chk("rr1_idx", 32'(unit_idx_o), 32'd1);
    chk("rr1_tag", 32'(unit_tag_o), 32'h11);
    chk("rr1_ready", 32'(req_ready), 32'b0010);
    step(); #1;
    chk("rr2_idx", 32'(unit_idx_o), 32'd2);
    chk("rr2_ready", 32'(req_ready), 32'b0100);
    step(); #1;
    chk("rr3_idx", 32'(unit_idx_o), 32'd3);
    chk("rr3_tag", 32'(unit_tag_o), 32'h13);
    chk("rr3_ready", 32'(req_ready), 32'b1000);
    step(); #1;
    chk("full_valid", 32'(unit_valid_o), 32'd0);
    chk("full_ready", 32'(req_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);

    // result for index 1 while full; req 3 waiting
    req_valid = 4'b1000; unit_valid_i = 1'b1; unit_idx_i = 2'd1;
    unit_tag_i = 8'hAB; rsp_ready = 4'hF; #1;
    chk("ret_rsp_valid", 32'(rsp_valid), 32'b0010);
    chk("ret_unit_ready", 32'(unit_ready_o), 32'd1);
    chk("ret_rsp_tag", 32'(rsp_tag), 32'hAB);
    chk("ret_full_valid", 32'(unit_valid_o), 32'd0);
    step();
    // cnt=3: issue req 3 and retire index 2 in the same cycle
    unit_idx_i = 2'd2; unit_tag_i = 8'hCD; #1;
    chk("resume_valid", 32'(unit_valid_o), 32'd1);
    chk("resume_idx", 32'(unit_idx_o), 32'd3);
    chk("resume_ready", 32'(req_ready), 32'b1000);
    chk("both_rsp_valid", 32'(rsp_valid), 32'b0100);
    step();
    // cnt must still be 3: exactly one more issue fits
    unit_valid_i = 1'b0; req_valid = 4'hF; #1;
    chk("cnt3_valid", 32'(unit_valid_o), 32'd1);
    chk("cnt3_idx", 32'(unit_idx_o), 32'd0);
    step(); #1;
    chk("cnt4_valid", 32'(unit_valid_o), 32'd0);

    // result for index 1 back-pressured by its requester
    unit_valid_i = 1'b1; unit_idx_i = 2'd1; rsp_ready = 4'b1101; #1;
    chk("bp_rsp_valid", 32'(rsp_valid), 32'b0010);
    chk("bp_unit_ready", 32'(unit_ready_o), 32'd0);
    step(); #1;
    chk("bp_hold_valid", 32'(unit_valid_o), 32'd0);
    chk("bp_hold_ready", 32'(unit_ready_o), 32'd0);
    rsp_ready = 4'hF; #1;
    chk("bp_release_ready", 32'(unit_ready_o), 32'd1);
    step();
    // cnt=3, ptr=1; stall to lock requester 1
    unit_valid_i = 1'b0; unit_ready_i = 1'b0; #1;
    chk("stall_valid", 32'(unit_valid_o), 32'd1);
    chk("stall_idx", 32'(unit_idx_o), 32'd1);
    chk("stall_ready", 32'(req_ready), 32'd0);

    // flush with a locked grant and three credits used
    step();
    flush = 1'b1; #1;
    chk("flush_fwd", 32'(unit_flush), 32'd1);
    chk("flush_idx", 32'(unit_idx_o), 32'd1);
    step();
    flush = 1'b0; req_valid = '0; #1;
    chk("flush_fwd_off", 32'(unit_flush), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_valid", 32'(unit_valid_o), 32'd0);
    // ptr kept at 1, lock gone: requesters 0 and 2 -> 2 first
    req_valid = 4'b0101; unit_ready_i = 1'b1; #1;
    chk("post_flush_idx", 32'(unit_idx_o), 32'd2);
    chk("post_flush_ready", 32'(req_ready), 32'b0100);
    step(); #1;
    chk("wrap_idx", 32'(unit_idx_o), 32'd0);
    chk("wrap_ready", 32'(req_ready), 32'b0001);
    step();
    // cnt=2: retire one, then issue req 3 to park ptr at 0
    req_valid = '0; unit_valid_i = 1'b1; unit_idx_i = 2'd0; #1;
    chk("ret0_rsp_valid", 32'(rsp_valid), 32'b0001);
    chk("ret0_unit_ready", 32'(unit_ready_o), 32'd1);
    step();
    unit_valid_i = 1'b0; req_valid = 4'b1000; #1;
    chk("park_idx", 32'(unit_idx_o), 32'd3);
    step();

    // stall on requester 2 while requester 0 rises (cnt=2, ptr=0)
    req_valid = 4'b0100; unit_ready_i = 1'b0; #1;
    chk("lk1_valid", 32'(unit_valid_o), 32'd1);
    chk("lk1_idx", 32'(unit_idx_o), 32'd2);
    chk("lk1_ready", 32'(req_ready), 32'd0);
    step();
    req_valid = 4'b0101; #1;
    chk("lk2_idx", 32'(unit_idx_o), 32'd2);
    chk("lk2_tag", 32'(unit_tag_o), 32'h12);
    chk("lk2_ready", 32'(req_ready), 32'd0);
    step(); #1;
    chk("lk3_idx", 32'(unit_idx_o), 32'd2);
    step();
    unit_ready_i = 1'b1; #1;
    chk("lk_accept_idx", 32'(unit_idx_o), 32'd2);
    chk("lk_accept_ready", 32'(req_ready), 32'b0100);
    step();
    req_valid = 4'b0001; #1;
    chk("lk_next_idx", 32'(unit_idx_o), 32'd0);
    chk("lk_next_ready", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'hF; #1;
    chk("full2_valid", 32'(unit_valid_o), 32'd0);
    chk("full2_busy", 32'(busy), 32'd1);

    // asynchronous reset mid-cycle (cnt=4, ptr=1)
    #2;
    rst = 1'b1; #1;
    chk("arst_valid", 32'(unit_valid_o), 32'd1);
    chk("arst_idx", 32'(unit_idx_o), 32'd0);
    req_valid = '0; #1;
    chk("arst_busy", 32'(busy), 32'd0);
    step();
    rst = 1'b0; req_valid = 4'b0110; #1;
    chk("post_rst_idx", 32'(unit_idx_o), 32'd1);
    chk("post_rst_ready", 32'(req_ready), 32'b0010);
    step(); #1;
    chk("post_rst_next", 32'(unit_idx_o), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpnew_rr_scheduler.md
# fpnew_rr_scheduler

Round-robin issue scheduler that shares one pipelined FPNew operation unit (a lane group plus its aux/handshake chain) between `NumReq` independent requesters. It sits directly in front of the unit. It arbitrates requests, stamps each issued operation with the requester index on the unit's aux channel, and bounds the number of operations in flight with a credit counter. Returning results are routed back to the originating requester by that index.

## Interface
Parameters:
- `NumReq`, 4, number of requesters (≥2)
- `MaxInflight`, 4, maximum operations outstanding inside the unit (≥1)
- `TagType`, logic, opaque per-operation tag passed through unchanged
- `IdxWidth`, derived: `$clog2(NumReq)`, requester index width

Ports:
- `clk_i`  in  1  clock, rising edge
- `rst_i`  in  1  asynchronous, active-high reset
- `flush_i`  in  1  synchronous flush of scheduler state
- `req_valid_i`  in  NumReq  per-requester request valid
- `req_ready_o`  out  NumReq  per-requester request accepted
- `req_tag_i`  in  NumReq×TagType  per-requester tag
- `unit_valid_o`  out  1  issue valid to the shared unit
- `unit_ready_i`  in  1  unit accepts the issue
- `unit_tag_o`  out  TagType  tag of the granted requester
- `unit_idx_o`  out  IdxWidth  granted requester index (driven onto the unit aux input)
- `unit_flush_o`  out  1  equals `flush_i`
- `unit_valid_i`  in  1  result valid from the unit
- `unit_ready_o`  out  1  result accepted
- `unit_tag_i`  in  TagType  result tag
- `unit_idx_i`  in  IdxWidth  result requester index (from the unit aux output)
- `rsp_valid_o`  out  NumReq  per-requester result valid
- `rsp_ready_i`  in  NumReq  per-requester result ready
- `rsp_tag_o`  out  TagType  result tag, shared by all requesters
- `busy_o`  out  1  operations in flight or an issue pending

## Operation
- State: round-robin pointer `ptr` (IdxWidth), grant lock `lock` plus `locked_idx`, credit counter `cnt` (width `$clog2(MaxInflight+1)`).
- Arbitration: candidate = first requester with `req_valid_i` set, searching from `ptr` upward and wrapping at `NumReq-1`→0. If `lock` is set, the candidate is `locked_idx` regardless of the other requesters.
- Issue enabled only when `cnt < MaxInflight`.
- Issue outputs:
  - `unit_valid_o` = a candidate exists and issue is enabled.
  - `unit_tag_o` and `unit_idx_o` carry the candidate's tag and index.
  - `req_ready_o[candidate]` = `unit_valid_o & unit_ready_i`.
  - All other bits of `req_ready_o` are 0.
- Issue handshake (`unit_valid_o & unit_ready_i`): `ptr` ← candidate+1 (mod NumReq), `lock` ← 0, `cnt` increments.
- Stall (`unit_valid_o & ~unit_ready_i`): `lock` ← 1 and `locked_idx` ← candidate. This keeps the grant stable so the unit never sees valid/tag change while it is stalled.
- Response routing:
  - `rsp_valid_o[unit_idx_i]` = `unit_valid_i`.
  - `unit_ready_o` = `rsp_ready_i[unit_idx_i]`.
  - `rsp_tag_o` = `unit_tag_i`.
  - A response handshake decrements `cnt`.
- Simultaneous issue and retire in the same cycle: `cnt` is unchanged.
- `cnt` saturates:
  - It never exceeds `MaxInflight`.
  - A retire while `cnt`==0 is a protocol error. An assertion fires and `cnt` stays 0.
- `unit_idx_i` ≥ NumReq (non-power-of-2 NumReq): no `rsp_valid_o` bit is set, `unit_ready_o`=0, and an assertion fires.
- Flush: `cnt` ← 0 and `lock` ← 0. `ptr` is kept. `flush_i` overrides any issue or retire in that cycle. The unit discards its contents via `unit_flush_o`.
- `busy_o` = (`cnt` ≠ 0) | `unit_valid_o`.

## Timing
- Reset values:
  - Registers: `ptr`=0, `lock`=0, `locked_idx`=0, `cnt`=0.
  - Outputs: `unit_valid_o`, `req_ready_o`, `rsp_valid_o` and `busy_o` all 0 unless the corresponding inputs are active. All paths are combinational from the registers and inputs.
- Issue path is zero-latency: a request is presented to the unit in the same cycle it is valid.
- Response path is combinational with zero added latency.
- A requester's request is accepted in cycle N only if that requester is the candidate in cycle N. The state update is visible in N+1.
- Fairness: with all requesters continuously valid and the unit always ready, grants cycle 0,1,…,NumReq-1,0.
- Reset asserted mid-operation clears all state asynchronously. In-flight results that return after reset release are protocol errors.

## Structure
- The package `fpnew_pkg` holds a helper function returning the index width for `NumReq`, with a minimum of 1.
- One sub-module: `fpnew_rr_pick`, a combinational wrap-around priority picker (inputs: request vector and start pointer; outputs: index and found flag).
- All registers live in the top module.

## Test plan
- All 4 requesters valid, `unit_ready_i`=1, result path idle, MaxInflight=4 → grants 0,1,2,3. `cnt` goes to 4 and `unit_valid_o` drops to 0 in cycle 5.
- Requester 2 valid and `unit_ready_i`=0 for 3 cycles while requester 0 rises in cycle 2 → `unit_idx_o` stays 2 throughout. Requester 2 is accepted when `unit_ready_i` rises, and requester 0 is issued next.
- `cnt`=4 and a result returns with `unit_idx_i`=1 while requester 3 is valid → `rsp_valid_o`=4'b0010. Issue resumes the next cycle. With issue and retire in the same cycle, `cnt` stays constant.
- `rsp_ready_i[1]`=0 with a result pending for index 1 → `unit_ready_o`=0 and `cnt` is unchanged until ready rises.
- `flush_i` pulse with `cnt`=3 and a locked grant → next cycle `cnt`=0, lock cleared, `ptr` unchanged, `unit_flush_o` equals `flush_i`, and `busy_o` is 0 if no request is valid.
- `rst_i` asserted mid-burst → all registers return to reset values immediately, and the first grant after release goes to the lowest valid index ≥ 0.
